// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx: source side of a 4-phase req/ack crossing; holds the word on data_out
// until the resynchronised ack returns to zero.
module cdc_handshake_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_STAGES = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  req_out,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  ack_in,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  tx_count
);
  typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;
  state_t                r_state, w_next;
  logic [NUM_STAGES-1:0] r_ack_sync;
  logic                  r_req, r_done;
  logic [DATA_WIDTH-1:0] r_data;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  w_ack_s, w_accept, w_complete;
  assign w_ack_s = r_ack_sync[NUM_STAGES-1];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_ack_sync <= '0;
    else      r_ack_sync <= {r_ack_sync[NUM_STAGES-2:0], ack_in};
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end
  always_comb begin
    w_next = (r_state == IDLE    &&  w_accept) ? REQ     :
             (r_state == REQ     &&  w_ack_s)  ? RELEASE :
             (r_state == RELEASE && !w_ack_s)  ? IDLE    : r_state;
  end
  always_comb begin
    in_ready   = (r_state == IDLE) && !w_ack_s;
    busy       = (r_state != IDLE);
    w_accept   = in_valid && in_ready;
    w_complete = (r_state == RELEASE) && !w_ack_s;
  end
  // req comes straight from its own flop so the crossing never sees a decode glitch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req  <= 1'b0;
      r_data <= '0;
      r_done <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_req  <= (w_next == REQ);
      r_data <= w_accept ? in_data : r_data;
      r_done <= w_complete;
      r_cnt  <= r_cnt + CNT_WIDTH'(w_complete);
    end
  end
  assign req_out  = r_req;
  assign data_out = r_data;
  assign done     = r_done;
  assign tx_count = r_cnt;
endmodule

// File: tb/tb_cdc_handshake_tx.sv
// tb_cdc_handshake_tx: directed checks of the 4-phase source; a second instance with a
// 4-bit counter shares the stimulus to exercise counter wrap.
module tb_cdc_handshake_tx;
  logic        clk = 1'b0, rst = 1'b0, in_valid = 1'b0, ack_in = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, req_out, busy, done;
  logic [7:0]  data_out;
  logic [15:0] tx_count;
  logic        in_ready4, req4, busy4, done4;
  logic [7:0]  data4;
  logic [3:0]  tx_count4;
  int n_checks = 0, n_fail = 0, exp_cnt = 0;

  cdc_handshake_tx dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .req_out(req_out), .data_out(data_out), .ack_in(ack_in), .busy(busy), .done(done),
    .tx_count(tx_count));

  cdc_handshake_tx #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready4),
    .req_out(req4), .data_out(data4), .ack_in(ack_in), .busy(busy4), .done(done4),
    .tx_count(tx_count4));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ack_cycle();
    int k;
    ack_in = 1'b1;
    k = 0;
    while (req_out !== 1'b0 && k < 40) begin tick(); k++; end
    n_checks++;
    if (req_out !== 1'b0) begin n_fail++; $display("FAIL ack_req_fall: req_out=%b required 0", req_out); end
    ack_in = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 40) begin tick(); k++; end
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL ack_done_seen: done=%b required 1", done); end
  endtask

  task automatic test_reset();
    tick(); tick();
    n_checks++;
    if (req_out !== 1'b0 || busy !== 1'b0 || data_out !== 8'h00 || tx_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_hold: req=%b busy=%b data=%h cnt=%0d required 0 0 00 0", req_out, busy, data_out, tx_count);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: in_ready=%b required 1", in_ready); end
    in_valid = 1'b1; in_data = 8'h77;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (req_out !== 1'b1 || data_out !== 8'h77) begin
      n_fail++; $display("FAIL reset_pre_accept: req=%b data=%h required 1 77", req_out, data_out);
    end
    #3 rst = 1'b0;
    #1;
    n_checks++;
    if (req_out !== 1'b0 || busy !== 1'b0 || data_out !== 8'h00 || tx_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_async: req=%b busy=%b data=%h cnt=%0d required 0 0 00 0", req_out, busy, data_out, tx_count);
    end
    tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: in_ready=%b busy=%b required 1 0", in_ready, busy);
    end
    exp_cnt = 0;
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_data = 8'hA5;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (data_out !== 8'hA5 || req_out !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL single_accept: data=%h req=%b busy=%b rdy=%b required a5 1 1 0", data_out, req_out, busy, in_ready);
    end
    tick();
    ack_in = 1'b1;
    tick(); tick();
    n_checks++;
    if (req_out !== 1'b1) begin n_fail++; $display("FAIL single_req_hold: req_out=%b required 1", req_out); end
    tick();
    n_checks++;
    if (req_out !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_req_fall: req=%b busy=%b required 0 1", req_out, busy);
    end
    ack_in = 1'b0;
    tick(); tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_done_early: done=%b busy=%b required 0 1", done, busy);
    end
    tick();
    exp_cnt++;
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || tx_count !== 16'(exp_cnt) || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL single_done: done=%b busy=%b cnt=%0d rdy=%b required 1 0 %0d 1", done, busy, tx_count, in_ready, exp_cnt);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || data_out !== 8'hA5) begin
      n_fail++; $display("FAIL single_done_pulse: done=%b data=%h required 0 a5", done, data_out);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    in_valid = 1'b1; in_data = 8'h11;
    tick();
    in_data = 8'h22;
    n_checks++;
    if (data_out !== 8'h11 || busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_first: data=%h busy=%b required 11 1", data_out, busy);
    end
    ack_in = 1'b1;
    k = 0;
    while (req_out !== 1'b0 && k < 40) begin
      tick(); k++;
      n_checks++;
      if (in_ready !== 1'b0 || data_out !== 8'h11) begin
        n_fail++; $display("FAIL b2b_req_phase: rdy=%b data=%h required 0 11", in_ready, data_out);
      end
    end
    ack_in = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 40) begin
      tick(); k++;
      n_checks++;
      if (busy === 1'b1 && (in_ready !== 1'b0 || data_out !== 8'h11)) begin
        n_fail++; $display("FAIL b2b_release_phase: rdy=%b data=%h required 0 11", in_ready, data_out);
      end
    end
    exp_cnt++;
    n_checks++;
    if (done !== 1'b1 || data_out !== 8'h11 || in_ready !== 1'b1 || tx_count !== 16'(exp_cnt)) begin
      n_fail++; $display("FAIL b2b_first_done: done=%b data=%h rdy=%b cnt=%0d required 1 11 1 %0d", done, data_out, in_ready, tx_count, exp_cnt);
    end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (data_out !== 8'h22 || busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_second: data=%h busy=%b required 22 1", data_out, busy);
    end
    ack_cycle();
    exp_cnt++;
    n_checks++;
    if (tx_count !== 16'(exp_cnt) || data_out !== 8'h22) begin
      n_fail++; $display("FAIL b2b_count: cnt=%0d data=%h required %0d 22", tx_count, data_out, exp_cnt);
    end
    tick();
  endtask

  task automatic test_stale_ack();
    ack_in = 1'b1;
    tick(); tick(); tick();
    n_checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL stale_block: rdy=%b busy=%b required 0 0", in_ready, busy);
    end
    in_valid = 1'b1; in_data = 8'hC3;
    tick(); tick();
    n_checks++;
    if (busy !== 1'b0 || req_out !== 1'b0 || data_out !== 8'h22) begin
      n_fail++; $display("FAIL stale_no_accept: busy=%b req=%b data=%h required 0 0 22", busy, req_out, data_out);
    end
    ack_in = 1'b0;
    tick();
    n_checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL stale_sync1: rdy=%b busy=%b required 0 0", in_ready, busy);
    end
    tick();
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL stale_ready: rdy=%b busy=%b required 1 0", in_ready, busy);
    end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || data_out !== 8'hC3 || req_out !== 1'b1) begin
      n_fail++; $display("FAIL stale_accept: busy=%b data=%h req=%b required 1 c3 1", busy, data_out, req_out);
    end
    ack_cycle();
    exp_cnt++;
    n_checks++;
    if (tx_count !== 16'(exp_cnt)) begin n_fail++; $display("FAIL stale_count: cnt=%0d required %0d", tx_count, exp_cnt); end
    tick();
  endtask

  task automatic test_reset_mid_req();
    in_valid = 1'b1; in_data = 8'h3C;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (req_out !== 1'b1 || data_out !== 8'h3C) begin
      n_fail++; $display("FAIL midrst_accept: req=%b data=%h required 1 3c", req_out, data_out);
    end
    tick(); tick();
    #3 rst = 1'b0;
    #1;
    exp_cnt = 0;
    n_checks++;
    if (req_out !== 1'b0 || busy !== 1'b0 || data_out !== 8'h00 || tx_count !== 16'd0) begin
      n_fail++; $display("FAIL midrst_async: req=%b busy=%b data=%h cnt=%0d required 0 0 00 0", req_out, busy, data_out, tx_count);
    end
    tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (done !== 1'b0 || tx_count !== 16'd0) begin
        n_fail++; $display("FAIL midrst_no_done: done=%b cnt=%0d required 0 0", done, tx_count);
      end
    end
    in_valid = 1'b1; in_data = 8'h5A;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (data_out !== 8'h5A || req_out !== 1'b1) begin
      n_fail++; $display("FAIL midrst_new_accept: data=%h req=%b required 5a 1", data_out, req_out);
    end
    ack_cycle();
    exp_cnt++;
    n_checks++;
    if (tx_count !== 16'(exp_cnt) || data_out !== 8'h5A) begin
      n_fail++; $display("FAIL midrst_new_done: cnt=%0d data=%h required %0d 5a", tx_count, data_out, exp_cnt);
    end
    tick();
  endtask

  task automatic test_wrap();
    #3 rst = 1'b0;
    #1;
    tick();
    rst = 1'b1;
    tick();
    for (int i = 1; i <= 17; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      tick();
      in_valid = 1'b0;
      ack_cycle();
      if (i == 15) begin
        n_checks++;
        if (tx_count4 !== 4'd15) begin n_fail++; $display("FAIL wrap_15: cnt4=%0d required 15", tx_count4); end
      end
      if (i == 16) begin
        n_checks++;
        if (tx_count4 !== 4'd0) begin n_fail++; $display("FAIL wrap_16: cnt4=%0d required 0", tx_count4); end
      end
      if (i == 17) begin
        n_checks++;
        if (tx_count4 !== 4'd1) begin n_fail++; $display("FAIL wrap_17: cnt4=%0d required 1", tx_count4); end
      end
      tick();
    end
    n_checks++;
    if (tx_count !== 16'd17 || data_out !== 8'd17) begin
      n_fail++; $display("FAIL wrap_wide: cnt=%0d data=%h required 17 11", tx_count, data_out);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stale_ack();
    test_reset_mid_req();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
